la_aoi32_pipe: RTL and testbench
================================

LA_AOI32_PIPE -- requirements
Module: la_aoi32_pipe

Interface
REQ-001 Parameter PROP, default "DEFAULT": implementation property string, passed unchanged to sub-modules.
REQ-002 Parameter CH, default 1: number of independent AOI32 channels, 1..64.
REQ-003 Parameter STAGES, default 1: pipeline depth, 1..4; any other value SHALL trigger an elaboration error.
REQ-004 Parameter INVERT, default 1: 1 gives AOI (~((a0&a1&a2)|(b0&b1))); 0 gives AO, the non-inverted form.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream holds a valid operand set.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 a0, a1, a2  input  CH each  three-input product term, bit i = channel i.
REQ-010 b0, b1  input  CH each  two-input product term, bit i = channel i.
REQ-011 out_valid  output  1  z carries a valid result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 z  output  CH  per-channel result.
REQ-014 occupancy  output  $clog2(STAGES+1)  number of results held in the pipeline.

Function
REQ-015 The block SHALL compute the logic function combinationally, before stage 0: f[i] = (a0[i]&a1[i]&a2[i]) | (b0[i]&b1[i]), inverted when INVERT=1.
REQ-016 A transfer on the input side SHALL occur on a cycle where in_valid&in_ready=1; on the output side, where out_valid&out_ready=1.
REQ-017 Each stage k SHALL hold a valid bit v[k] and CH data bits; stage STAGES-1 drives out_valid and z.
REQ-018 Stage k SHALL load when ready[k] = ~v[k] | ready[k+1], with ready[STAGES] = out_ready; in_ready = ready[0].
REQ-019 in_ready SHALL be combinational from out_ready and the valid bits, and SHALL NOT depend on in_valid.
REQ-020 Latency: a result SHALL appear on z exactly STAGES cycles after acceptance when the downstream never stalls.
REQ-021 Throughput: one result per cycle when in_valid=out_ready=1 continuously; no bubbles are inserted.
REQ-022 While out_valid=1 and out_ready=0, z and out_valid SHALL stay stable.
REQ-023 Results SHALL leave in acceptance order; the block SHALL NOT drop, duplicate or reorder results.
REQ-024 occupancy SHALL increment on input transfer only, decrement on output transfer only, and stay unchanged on both or neither; it SHALL equal the popcount of v.
REQ-025 When full (occupancy=STAGES) and out_ready=0, in_ready SHALL be 0; a simultaneous output transfer on a full pipeline SHALL allow an input transfer in the same cycle.
REQ-026 When empty, out_valid SHALL be 0 and z SHALL hold its last value. z is don't-care to consumers.

Reset
REQ-027 While reset=1 at a rising clk edge, every v[k] SHALL clear to 0, stage data to 0 and occupancy to 0; out_valid=0 and z=0 in the following cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight results, with no output transfer after the reset edge.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 A shared package la_stdlib_pkg SHALL hold LA_PIPE_MAX_STAGES=4 and the occupancy-width function; no other typedefs are required.
REQ-031 One sub-module, la_pipe_stage, SHALL implement a single valid/ready register stage (parameter W), instantiated STAGES times.
REQ-032 Logic evaluation SHALL be a generate loop over CH, placed before stage 0.

Verification
REQ-033 CH=4, STAGES=2, INVERT=1. Drive a0=a1=a2=4'b1010, b0=4'b0101, b1=4'b0100 with out_ready=1 -> z=4'b0001 two cycles after acceptance.
REQ-034 INVERT=0, same stimulus -> z=4'b1110; all-zero inputs -> z=4'b0000.
REQ-035 STAGES=3. Hold out_ready=0 and push 4 items -> in_ready drops after 3 acceptances, occupancy=3, z stays stable; release -> 3 results in order.
REQ-036 Full pipeline, in_valid=out_ready=1 for 10 cycles -> 10 transfers each side, occupancy constant at STAGES.
REQ-037 Assert reset with occupancy=2 -> next cycle out_valid=0, occupancy=0, in_ready=1; no stale result emerges.
REQ-038 Random valid/ready stimulus over 10k cycles -> scoreboard matches the per-channel AOI32 model in order; occupancy invariant holds on every cycle.

Source files
------------

// File: rtl/la_stdlib_pkg.sv
// Shared pipeline constants and sizing helpers for the la_* block library.
package la_stdlib_pkg;

  localparam int LA_PIPE_MAX_STAGES = 4;

  // Width of a counter that must represent 0..stages inclusive.
  function automatic int la_occ_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/la_pipe_stage.sv
// One valid/ready register slice: accepts when empty or when downstream drains it.
module la_pipe_stage #(
  parameter string PROP = "DEFAULT",
  parameter int    W    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  if (PROP == "") begin : g_bad_prop
    $error("la_pipe_stage: PROP must name an implementation");
  end

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  // NOTE: state uses non-blocking assignments; data is cleared on reset so z reads 0 right after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/la_aoi32_pipe.sv
// Per-channel AOI32/AO32 evaluated combinationally, then carried through a valid/ready pipeline.
module la_aoi32_pipe
  import la_stdlib_pkg::*;
#(
  parameter string PROP   = "DEFAULT",
  parameter int    CH     = 1,
  parameter int    STAGES = 1,
  parameter int    INVERT = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CH-1:0]                     a0,
  input  logic [CH-1:0]                     a1,
  input  logic [CH-1:0]                     a2,
  input  logic [CH-1:0]                     b0,
  input  logic [CH-1:0]                     b1,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CH-1:0]                     z,
  output logic [la_occ_width(STAGES)-1:0]   occupancy
);

  localparam int OW = la_occ_width(STAGES);

  if (STAGES < 1 || STAGES > LA_PIPE_MAX_STAGES) begin : g_bad_stages
    $error("la_aoi32_pipe: STAGES must be 1..%0d", LA_PIPE_MAX_STAGES);
  end
  if (CH < 1 || CH > 64) begin : g_bad_ch
    $error("la_aoi32_pipe: CH must be 1..64");
  end

  logic [CH-1:0] f;

  for (genvar i = 0; i < CH; i++) begin : g_logic
    logic ao;
    assign ao   = (a0[i] & a1[i] & a2[i]) | (b0[i] & b1[i]);
    assign f[i] = (INVERT != 0) ? ~ao : ao;
  end

  // Index k is the input side of stage k; index STAGES is the block output.
  logic [STAGES:0]         valid;
  logic [STAGES:0]         ready;
  logic [STAGES:0][CH-1:0] data;

  assign valid[0]      = in_valid;
  assign data[0]       = f;
  assign ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    la_pipe_stage #(
      .PROP (PROP),
      .W    (CH)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (valid[k]),
      .in_ready  (ready[k]),
      .in_data   (data[k]),
      .out_valid (valid[k+1]),
      .out_data  (data[k+1]),
      .out_ready (ready[k+1])
    );
  end

  assign in_ready  = ready[0];
  assign out_valid = valid[STAGES];
  assign z         = data[STAGES];

  logic          in_xfer, out_xfer;
  logic [OW-1:0] occ_q, occ_d;

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign occupancy = occ_q;

  always_comb begin
    occ_d = occ_q;
    case ({in_xfer, out_xfer})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

endmodule

// File: tb/tb_la_aoi32_pipe.sv
// Directed bench: AOI/AO configs with STAGES=2, plus stall, throughput, random and reset on STAGES=3.
module tb_la_aoi32_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] a0, a1, a2, b0, b1, input bit inv);
    logic [3:0] m;
    m = (a0 & a1 & a2) | (b0 & b1);
    return inv ? ~m : m;
  endfunction

  // Shared stimulus for the INVERT=1 (a) and INVERT=0 (b) STAGES=2 instances.
  logic       in_valid_ab, out_ready_ab;
  logic [3:0] a0_ab, a1_ab, a2_ab, b0_ab, b1_ab;
  logic       ready_a, valid_a, ready_b, valid_b;
  logic [3:0] z_a, z_b;
  logic [1:0] occ_a, occ_b;

  la_aoi32_pipe #(.PROP("DEFAULT"), .CH(4), .STAGES(2), .INVERT(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_ab), .in_ready(ready_a),
    .a0(a0_ab), .a1(a1_ab), .a2(a2_ab), .b0(b0_ab), .b1(b1_ab),
    .out_valid(valid_a), .out_ready(out_ready_ab), .z(z_a), .occupancy(occ_a));

  la_aoi32_pipe #(.PROP("DEFAULT"), .CH(4), .STAGES(2), .INVERT(0)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_ab), .in_ready(ready_b),
    .a0(a0_ab), .a1(a1_ab), .a2(a2_ab), .b0(b0_ab), .b1(b1_ab),
    .out_valid(valid_b), .out_ready(out_ready_ab), .z(z_b), .occupancy(occ_b));

  logic       in_valid_c, out_ready_c;
  logic [3:0] a0_c, a1_c, a2_c, b0_c, b1_c;
  logic       ready_c, valid_c;
  logic [3:0] z_c;
  logic [1:0] occ_c;

  la_aoi32_pipe #(.PROP("DEFAULT"), .CH(4), .STAGES(3), .INVERT(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(ready_c),
    .a0(a0_c), .a1(a1_c), .a2(a2_c), .b0(b0_c), .b1(b1_c),
    .out_valid(valid_c), .out_ready(out_ready_c), .z(z_c), .occupancy(occ_c));

  logic [3:0] exp_q[$];

  // One cycle on dut_c: drive, observe handshakes, score output, advance the clock, check occupancy.
  task automatic drive_c(input logic v, input logic [3:0] a0, a1, a2, b0, b1,
                         input logic r, output logic in_x, output logic out_x);
    in_valid_c = v; a0_c = a0; a1_c = a1; a2_c = a2; b0_c = b0; b1_c = b1;
    out_ready_c = r;
    #1;
    in_x  = v & ready_c;
    out_x = valid_c & r;
    if (out_x) begin
      if (exp_q.size() == 0) check("c_unexpected_out", {28'd0, z_c}, 32'hdead);
      else                   check("c_order", {28'd0, z_c}, {28'd0, exp_q.pop_front()});
    end
    if (in_x) exp_q.push_back(model(a0, a1, a2, b0, b1, 1'b1));
    @(posedge clk); #1;
    check("c_occ_model", {30'd0, occ_c}, exp_q.size());
  endtask

  initial begin
    logic       ix, ox;
    int         n_in, n_out;
    logic [3:0] z_hold;
    logic [3:0] items [4];
    items = '{4'h1, 4'h2, 4'h3, 4'h4};

    reset = 1'b1;
    in_valid_ab = 1'b0; out_ready_ab = 1'b0;
    {a0_ab, a1_ab, a2_ab, b0_ab, b1_ab} = '0;
    in_valid_c = 1'b0; out_ready_c = 1'b0;
    {a0_c, a1_c, a2_c, b0_c, b1_c} = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_valid_a", valid_a, 0);
    check("rst_z_a", z_a, 0);
    check("rst_occ_a", occ_a, 0);
    check("rst_ready_a", ready_a, 1);
    check("rst_z_b", z_b, 0);
    check("rst_ready_c", ready_c, 1);
    check("rst_occ_c", occ_c, 0);

    // AOI vs AO, two-cycle latency.
    a0_ab = 4'b1010; a1_ab = 4'b1010; a2_ab = 4'b1010; b0_ab = 4'b0101; b1_ab = 4'b0100;
    in_valid_ab = 1'b1; out_ready_ab = 1'b1;
    #1;
    check("ab_accept", ready_a, 1);
    @(posedge clk); #1;
    in_valid_ab = 1'b0;
    check("ab_lat1_valid", valid_a, 0);
    check("ab_lat1_occ", occ_a, 1);
    @(posedge clk); #1;
    check("ab_lat2_valid", valid_a, 1);
    check("ab_aoi_z", z_a, 4'b0001);
    check("ab_ao_z", z_b, 4'b1110);
    check("ab_lat2_occ", occ_a, 1);
    @(posedge clk); #1;
    check("ab_drained_valid", valid_a, 0);
    check("ab_drained_hold", z_a, 4'b0001);
    check("ab_drained_occ", occ_b, 0);

    {a0_ab, a1_ab, a2_ab, b0_ab, b1_ab} = '0;
    in_valid_ab = 1'b1;
    @(posedge clk); #1;
    in_valid_ab = 1'b0;
    @(posedge clk); #1;
    check("ab_zero_valid", valid_b, 1);
    check("ab_zero_ao", z_b, 4'b0000);
    check("ab_zero_aoi", z_a, 4'b1111);

    // Stall: 4 pushes into 3 stages with out_ready=0.
    n_in = 0;
    for (int j = 0; j < 4; j++) begin
      drive_c(1'b1, items[j], items[j], items[j], 4'h0, 4'h0, 1'b0, ix, ox);
      if (ix) n_in++;
      if (j == 3) check("stall_4th_refused", ix, 0);
    end
    check("stall_accepts", n_in, 3);
    check("stall_occ", occ_c, 3);
    in_valid_c = 1'b1; #1;
    check("stall_in_ready", ready_c, 0);
    z_hold = z_c;
    check("stall_first_z", z_c, 4'hE);
    for (int j = 0; j < 3; j++) begin
      drive_c(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, ix, ox);
      check("stall_z_stable", z_c, z_hold);
      check("stall_valid_stable", valid_c, 1);
    end
    n_out = 0;
    for (int j = 0; j < 8; j++) begin
      drive_c(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, ix, ox);
      if (ox) n_out++;
    end
    check("release_count", n_out, 3);

    // Full pipeline streaming: one in and one out every cycle.
    for (int j = 0; j < 3; j++)
      drive_c(1'b1, 4'(j + 5), 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, ix, ox);
    check("full_occ", occ_c, 3);
    n_in = 0; n_out = 0;
    for (int j = 0; j < 10; j++) begin
      drive_c(1'b1, 4'(j), 4'hF, 4'hF, 4'(j + 3), 4'h6, 1'b1, ix, ox);
      if (ix) n_in++;
      if (ox) n_out++;
      check("stream_occ_const", occ_c, 3);
    end
    check("stream_in_xfers", n_in, 10);
    check("stream_out_xfers", n_out, 10);

    // Random valid/ready with scoreboard.
    for (int j = 0; j < 10000; j++)
      drive_c(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), ix, ox);
    for (int j = 0; j < 10; j++)
      drive_c(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, ix, ox);
    check("random_drained", exp_q.size(), 0);

    // Mid-operation reset with two results in flight.
    for (int j = 0; j < 2; j++)
      drive_c(1'b1, 4'h3, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0, ix, ox);
    check("prerst_occ", occ_c, 2);
    in_valid_c = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", valid_c, 0);
    check("midrst_occ", occ_c, 0);
    check("midrst_ready", ready_c, 1);
    check("midrst_z", z_c, 0);
    for (int j = 0; j < 5; j++) begin
      drive_c(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, ix, ox);
      check("midrst_no_stale", valid_c, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
